// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler
// Collects three bytes from the UART receiver into one 24-bit command (byte0 in
// the MSBs) and hands it to the command processor with a cmd_rdy/clr_cmd_rdy
// handshake. A partial command is dropped if the receiver goes quiet for
// TIMEOUT clocks. Completing a command while the previous one is still
// unacknowledged overwrites it and raises overrun_err for one cycle.
module uart_cmd_assembler #(
  parameter int unsigned TIMEOUT = 52080  // clocks allowed between bytes, 2..131071
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        rx_rdy_clr,
  input  logic        clr_cmd_rdy,
  output logic [23:0] cmd,
  output logic        cmd_rdy,
  output logic        timeout_err,
  output logic        overrun_err
);

  typedef enum logic [1:0] {
    WAIT_B0 = 2'd0,
    WAIT_B1 = 2'd1,
    WAIT_B2 = 2'd2
  } state_e;

  localparam logic [16:0] TIMER_LAST = 17'(TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  hi_q;
  logic [7:0]  mid_q;
  logic [16:0] timer_q;
  logic [16:0] timer_d;
  logic [23:0] cmd_q;
  logic        cmd_rdy_q;
  logic        timeout_err_q;
  logic        overrun_err_q;

  logic        accept;
  logic        timer_hit;

  // Every state takes the byte as soon as it is offered; there is no backpressure.
  assign accept     = rx_rdy;
  assign rx_rdy_clr = accept;

  // Timer expiry only counts when no byte arrives the same cycle: an accept wins.
  assign timer_hit  = (timer_q == TIMER_LAST) && !accept;
  assign timer_d    = timer_q + 17'd1;

  // Byte-collection FSM with inter-byte timer, command register and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_B0;
      hi_q          <= 8'h00;
      mid_q         <= 8'h00;
      timer_q       <= 17'd0;
      cmd_q         <= 24'h000000;
      cmd_rdy_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every read below see the value from
      // the start of the cycle, and let a later assignment to the same register
      // in this block override an earlier one. That ordering is what makes a
      // completion win over a simultaneous clr_cmd_rdy.
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      if (clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end

      case (state_q)
        WAIT_B0: begin
          timer_q <= 17'd0;
          if (accept) begin
            hi_q    <= rx_data;
            state_q <= WAIT_B1;
          end
        end

        WAIT_B1: begin
          if (accept) begin
            mid_q   <= rx_data;
            timer_q <= 17'd0;
            state_q <= WAIT_B2;
          end else if (timer_hit) begin
            timer_q       <= 17'd0;
            timeout_err_q <= 1'b1;
            state_q       <= WAIT_B0;
          end else begin
            timer_q <= timer_d;
          end
        end

        WAIT_B2: begin
          if (accept) begin
            cmd_q         <= {hi_q, mid_q, rx_data};
            cmd_rdy_q     <= 1'b1;
            overrun_err_q <= cmd_rdy_q && !clr_cmd_rdy;
            timer_q       <= 17'd0;
            state_q       <= WAIT_B0;
          end else if (timer_hit) begin
            timer_q       <= 17'd0;
            timeout_err_q <= 1'b1;
            state_q       <= WAIT_B0;
          end else begin
            timer_q <= timer_d;
          end
        end

        default: begin
          timer_q <= 17'd0;
          state_q <= WAIT_B0;
        end
      endcase
    end
  end

  assign cmd         = cmd_q;
  assign cmd_rdy     = cmd_rdy_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;

endmodule
